// File: rtl/simd_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : simd_writeback_unit
// Purpose  : Aligns decoder result controls with PE-lane results and drives
//            the result-memory write port (vector or dot-product reduction).
// Options  : SIMD_WB_SAT_ACC_EN - signed saturating accumulator + acc_ovf
// Revision : 1.0 - initial release
// ============================================================================
module simd_writeback_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 4,
    parameter int PE_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           r_addr,
    input  logic                            write_en,
    input  logic                            r_select,
    input  logic                            dot_prod_en,
    input  logic                            shift,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] pe_result,
    output logic                            wr_en,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [NUM_LANES*DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0]           acc_out,
    output logic                            wb_pending,
    output logic                            acc_ovf
);

    localparam int LANE_W = NUM_LANES * DATA_WIDTH;

    // Control delay line; the last stage lines up with the current pe_result.
    logic [ADDR_WIDTH-1:0] addr_pipe [PE_LATENCY];
    logic [PE_LATENCY-1:0] we_pipe;
    logic [PE_LATENCY-1:0] sel_pipe;
    logic [PE_LATENCY-1:0] dot_pipe;
    logic [PE_LATENCY-1:0] shift_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PE_LATENCY; k++) begin
                addr_pipe[k] <= '0;
            end
            we_pipe    <= '0;
            sel_pipe   <= '0;
            dot_pipe   <= '0;
            shift_pipe <= '0;
        end else begin
            addr_pipe[0]  <= r_addr;
            we_pipe[0]    <= write_en;
            sel_pipe[0]   <= r_select;
            dot_pipe[0]   <= dot_prod_en;
            shift_pipe[0] <= shift;
            for (int k = 1; k < PE_LATENCY; k++) begin
                addr_pipe[k]  <= addr_pipe[k-1];
                we_pipe[k]    <= we_pipe[k-1];
                sel_pipe[k]   <= sel_pipe[k-1];
                dot_pipe[k]   <= dot_pipe[k-1];
                shift_pipe[k] <= shift_pipe[k-1];
            end
        end
    end

    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_write_en;
    logic                  d_r_select;
    logic                  d_dot_prod_en;
    logic                  d_shift;

    assign d_addr        = addr_pipe[PE_LATENCY-1];
    assign d_write_en    = we_pipe[PE_LATENCY-1];
    assign d_r_select    = sel_pipe[PE_LATENCY-1];
    assign d_dot_prod_en = dot_pipe[PE_LATENCY-1];
    assign d_shift       = shift_pipe[PE_LATENCY-1];

    logic [LANE_W-1:0] rotated;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_rot
            assign rotated[i*DATA_WIDTH +: DATA_WIDTH] =
                pe_result[((i + 1) % NUM_LANES)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic [DATA_WIDTH-1:0] red_value;

`ifdef SIMD_WB_SAT_ACC_EN
    // Headroom for the full signed lane sum plus the accumulator.
    localparam int SUM_W = DATA_WIDTH + $clog2(NUM_LANES) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [SUM_W-1:0] wide_lanes;
    logic signed [SUM_W-1:0] wide_total;
    logic [DATA_WIDTH-1:0]   lane_word;
    logic                    sat_hit;
    logic                    ovf_flag;

    always_comb begin
        wide_lanes = '0;
        lane_word  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_word  = pe_result[i*DATA_WIDTH +: DATA_WIDTH];
            wide_lanes = wide_lanes +
                {{(SUM_W-DATA_WIDTH){lane_word[DATA_WIDTH-1]}}, lane_word};
        end
        wide_total = {{(SUM_W-DATA_WIDTH){acc[DATA_WIDTH-1]}}, acc} + wide_lanes;
        sat_hit = 1'b0;
        acc_sum = wide_total[DATA_WIDTH-1:0];
        if (wide_total > SAT_MAX) begin
            acc_sum = SAT_MAX[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (wide_total < SAT_MIN) begin
            acc_sum = SAT_MIN[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
        end else if (d_dot_prod_en && sat_hit) begin
            ovf_flag <= 1'b1;
        end
    end

    assign acc_ovf = ovf_flag;
`else
    logic [DATA_WIDTH-1:0] lane_sum;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_sum = lane_sum + pe_result[i*DATA_WIDTH +: DATA_WIDTH];
        end
        acc_sum = acc + lane_sum;
    end

    assign acc_ovf = 1'b0;
`endif

    assign red_value = d_dot_prod_en ? acc_sum : acc;

    // A reduction write consumes the accumulator, so it restarts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (d_write_en && d_r_select) begin
            acc <= '0;
        end else if (d_dot_prod_en) begin
            acc <= acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= d_write_en;
            if (d_write_en) begin
                wr_addr <= d_addr;
                if (d_r_select) begin
                    wr_data <= {{(LANE_W-DATA_WIDTH){1'b0}}, red_value};
                end else if (d_shift) begin
                    wr_data <= rotated;
                end else begin
                    wr_data <= pe_result;
                end
            end
        end
    end

    assign wb_pending = (|we_pipe) | wr_en;
    assign acc_out    = acc;

endmodule
`default_nettype wire

// File: tb/tb_simd_writeback_unit.sv
`default_nettype none
// Testbench for simd_writeback_unit: directed vector table, a reset-mid-flight
// sequence, and randomized traffic checked against a queue-based reference.
module tb_simd_writeback_unit;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NL = 4;
    localparam int PL = 2;
    localparam int LW = NL * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] r_addr;
    logic          write_en;
    logic          r_select;
    logic          dot_prod_en;
    logic          shift;
    logic [LW-1:0] pe_result;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_data;
    logic [DW-1:0] acc_out;
    logic          wb_pending;
    logic          acc_ovf;

    simd_writeback_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(NL), .PE_LATENCY(PL)
    ) dut (
        .clk(clk), .rst(rst), .r_addr(r_addr), .write_en(write_en),
        .r_select(r_select), .dot_prod_en(dot_prod_en), .shift(shift),
        .pe_result(pe_result), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .acc_out(acc_out), .wb_pending(wb_pending),
        .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit [AW-1:0] a, input bit we, input bit sel,
                         input bit dot, input bit sh, input bit [LW-1:0] pe);
        rst = r; r_addr = a; write_en = we; r_select = sel;
        dot_prod_en = dot; shift = sh; pe_result = pe;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit [AW-1:0] addr;
        bit          we, sel, dot, sh;
        bit [LW-1:0] pe;
        bit          e_wr_en;
        bit [AW-1:0] e_addr;
        bit [LW-1:0] e_data;
        bit [DW-1:0] e_acc;
        bit          e_pend;
        bit          e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit [AW-1:0] a, bit we, bit sel, bit dot, bit sh,
                                bit [LW-1:0] pe, bit ewr, bit [AW-1:0] ea,
                                bit [LW-1:0] ed, bit [DW-1:0] eacc, bit ep, bit eo);
        vec_t v;
        v.rst = r; v.addr = a; v.we = we; v.sel = sel; v.dot = dot; v.sh = sh; v.pe = pe;
        v.e_wr_en = ewr; v.e_addr = ea; v.e_data = ed; v.e_acc = eacc;
        v.e_pend = ep; v.e_ovf = eo;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit [AW-1:0] addr;
        bit          we, sel, dot, sh;
    } ctl_t;

    ctl_t        q[$];
    bit [DW-1:0] m_acc;
    bit          m_ovf;
    bit          m_wr_en;
    bit [AW-1:0] m_addr;
    bit [LW-1:0] m_data;
    bit          m_pend;

    function automatic bit [DW-1:0] lane_of(bit [LW-1:0] v, int i);
        return v[i*DW +: DW];
    endfunction

    task automatic model_step(input bit r, input ctl_t c, input bit [LW-1:0] pe);
        ctl_t        d;
        ctl_t        z;
        bit [DW-1:0] sum_v;
        bit [DW-1:0] v;
        bit          sat;
        longint      s_signed;
        bit [DW-1:0] s_wrap;
        longint      tot;
        z = '{default: 0};
        if (r) begin
            q = {};
            for (int k = 0; k < PL; k++) q.push_back(z);
            m_acc = '0; m_ovf = 0; m_wr_en = 0; m_addr = '0; m_data = '0;
        end else begin
            d = q.pop_front();
            q.push_back(c);
            s_signed = 0; s_wrap = '0; sat = 0;
            for (int i = 0; i < NL; i++) begin
                s_wrap   = s_wrap + lane_of(pe, i);
                s_signed = s_signed + longint'($signed(lane_of(pe, i)));
            end
`ifdef SIMD_WB_SAT_ACC_EN
            tot = longint'($signed(m_acc)) + s_signed;
            if (tot > 64'sd2147483647) begin
                sum_v = 32'h7FFF_FFFF; sat = 1;
            end else if (tot < -64'sd2147483648) begin
                sum_v = 32'h8000_0000; sat = 1;
            end else begin
                sum_v = tot[DW-1:0];
            end
`else
            tot   = 0;
            sum_v = m_acc + s_wrap;
`endif
            v = d.dot ? sum_v : m_acc;
            m_wr_en = d.we;
            if (d.we) begin
                m_addr = d.addr;
                if (d.sel) m_data = {{(LW-DW){1'b0}}, v};
                else if (d.sh) begin
                    for (int i = 0; i < NL; i++) m_data[i*DW +: DW] = lane_of(pe, (i + 1) % NL);
                end else m_data = pe;
            end
            if (d.dot && sat) m_ovf = 1;
            if (d.we && d.sel) m_acc = '0;
            else if (d.dot) m_acc = sum_v;
        end
        m_pend = m_wr_en;
        foreach (q[k]) if (q[k].we) m_pend = 1;
    endtask

    function automatic bit [LW-1:0] pack4(bit [DW-1:0] l0, bit [DW-1:0] l1,
                                           bit [DW-1:0] l2, bit [DW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    bit [LW-1:0] rnd_pe;
    bit [LW-1:0] big;
    bit [LW-1:0] l1234;
    bit [LW-1:0] l5678;
    bit [DW-1:0] ovf_v;
    bit          ovf_e;

    initial begin
        drive(1, '0, 0, 0, 0, 0, '0);
        l1234 = pack4(1, 2, 3, 4);
        l5678 = pack4(5, 6, 7, 8);
        big   = {NL{32'h7FFF_FFFF}};
`ifdef SIMD_WB_SAT_ACC_EN
        ovf_v = 32'h7FFF_FFFF; ovf_e = 1;
`else
        ovf_v = 32'hFFFF_FFFC; ovf_e = 0;
`endif
        // Reset with random inputs
        for (int k = 0; k < 2; k++) begin
            rnd_pe = {$urandom, $urandom, $urandom, $urandom};
            tbl.push_back(mk(1, AW'($urandom), 1, $urandom_range(0,1) == 1, 1, 1, rnd_pe,
                             0, '0, '0, '0, 0, 0));
        end
        // Vector write, then shifted write
        for (int s = 0; s < 2; s++) begin
            tbl.push_back(mk(0, 5, 1, 0, 0, s == 1, '0, 0, 0, 0, 0, 1, 0));
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 1, 0));
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, l1234, 1, 5,
                             (s == 1) ? pack4(2, 3, 4, 1) : l1234, 0, 1, 0));
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0));
        end
        // Dot product in two chunks
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 9, 1, 1, 1, 0, '0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, l1234, 0, 0, 0, 10, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, l5678, 1, 9, pack4(36, 0, 0, 0), 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0));
        // Overflow
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 1, 0, 1, '0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, big, 0, 0, 0, ovf_v, 1, ovf_e));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, l5678, 1, 3, pack4(ovf_v, 0, 0, 0), 0, 1, ovf_e));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, ovf_e));

        foreach (tbl[n]) begin
            drive(tbl[n].rst, tbl[n].addr, tbl[n].we, tbl[n].sel, tbl[n].dot, tbl[n].sh, tbl[n].pe);
            tick();
            check($sformatf("tbl%0d wr_en", n), wr_en, tbl[n].e_wr_en);
            check($sformatf("tbl%0d pending", n), wb_pending, tbl[n].e_pend);
            check($sformatf("tbl%0d acc", n), acc_out, tbl[n].e_acc);
            check($sformatf("tbl%0d ovf", n), acc_ovf, tbl[n].e_ovf);
            if (tbl[n].e_wr_en || tbl[n].rst) begin
                check($sformatf("tbl%0d addr", n), wr_addr, tbl[n].e_addr);
                check($sformatf("tbl%0d data", n), wr_data, tbl[n].e_data);
            end
        end

        // Reset mid-flight: preload acc=10, issue a write, then reset.
        drive(1, '0, 0, 0, 0, 0, '0); tick();
        drive(0, '0, 0, 0, 1, 0, '0); tick();
        drive(0, '0, 0, 0, 0, 0, '0); tick();
        drive(0, '0, 0, 0, 0, 0, l1234); tick();
        check("mid preload acc", acc_out, 10);
        drive(0, 11, 1, 0, 0, 0, l5678); tick();
        drive(1, 12, 1, 1, 1, 0, l5678); tick();
        for (int c = 2; c <= 6; c++) begin
            check($sformatf("mid c%0d wr_en", c), wr_en, 0);
            check($sformatf("mid c%0d acc", c), acc_out, 0);
            check($sformatf("mid c%0d pending", c), wb_pending, 0);
            drive(0, '0, 0, 0, 0, 0, l5678);
            tick();
        end

        // Randomized traffic against the reference model
        begin
            ctl_t c;
            drive(1, '0, 0, 0, 0, 0, '0);
            tick();
            model_step(1, '{default: 0}, '0);
            for (int n = 0; n < 400; n++) begin
                c.addr = AW'($urandom);
                c.we   = $urandom_range(0, 1) == 1;
                c.sel  = $urandom_range(0, 2) == 0;
                c.dot  = $urandom_range(0, 1) == 1;
                c.sh   = $urandom_range(0, 1) == 1;
                for (int i = 0; i < NL; i++) begin
                    case ($urandom_range(0, 5))
                        0:       rnd_pe[i*DW +: DW] = 32'h7FFF_FFFF;
                        1:       rnd_pe[i*DW +: DW] = 32'h8000_0000;
                        2:       rnd_pe[i*DW +: DW] = DW'($urandom_range(0, 15));
                        default: rnd_pe[i*DW +: DW] = $urandom;
                    endcase
                end
                drive($urandom_range(0, 39) == 0, c.addr, c.we, c.sel, c.dot, c.sh, rnd_pe);
                tick();
                model_step(rst, c, rnd_pe);
                check($sformatf("rnd%0d wr_en", n), wr_en, m_wr_en);
                check($sformatf("rnd%0d addr", n), wr_addr, m_addr);
                check($sformatf("rnd%0d data", n), wr_data, m_data);
                check($sformatf("rnd%0d acc", n), acc_out, m_acc);
                check($sformatf("rnd%0d pending", n), wb_pending, m_pend);
                check($sformatf("rnd%0d ovf", n), acc_ovf, m_ovf);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
